// File: rtl/alu_rr_sequencer.sv
// Two-requester front end for one shared registered ALU: round-robin grant,
// a single operation in flight, and a response held until its owner accepts it.
module alu_rr_sequencer #(
   parameter int WIDTH   = 32,
   parameter int ALU_LAT = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [2*WIDTH-1:0] req_a,
   input  logic [2*WIDTH-1:0] req_b,
   input  logic [7:0]         req_sel,
   output logic [WIDTH-1:0]   alu_a,
   output logic [WIDTH-1:0]   alu_b,
   output logic [3:0]         alu_sel,
   input  logic [WIDTH-1:0]   alu_out,
   input  logic               alu_flag,
   output logic [1:0]         rsp_valid,
   input  logic [1:0]         rsp_ready,
   output logic [WIDTH-1:0]   rsp_out,
   output logic               rsp_flag,
   output logic               busy
);
   localparam int CW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
   localparam logic [CW-1:0] LAT_LAST = CW'(ALU_LAT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             rr_ptr_q, rr_ptr_d;
   logic             owner_q, owner_d;
   logic [CW-1:0]    lat_cnt_q, lat_cnt_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [3:0]       alu_sel_q, alu_sel_d;
   logic [WIDTH-1:0] rsp_out_q, rsp_out_d;
   logic             rsp_flag_q, rsp_flag_d;

   logic [WIDTH-1:0] slice_a   [2];
   logic [WIDTH-1:0] slice_b   [2];
   logic [3:0]       slice_sel [2];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
         assign slice_a[gi]   = req_a[gi*WIDTH +: WIDTH];
         assign slice_b[gi]   = req_b[gi*WIDTH +: WIDTH];
         assign slice_sel[gi] = req_sel[gi*4 +: 4];
      end
   endgenerate

   // A lone requester wins outright; on contention rr_ptr picks the winner.
   logic grant_any, grant_idx;
   assign grant_any = (state_q == IDLE) && (req_valid != 2'b00);
   assign grant_idx = req_valid[1] & (~req_valid[0] | rr_ptr_q);

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      lat_cnt_d  = lat_cnt_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_sel_d  = alu_sel_q;
      rsp_out_d  = rsp_out_q;
      rsp_flag_d = rsp_flag_q;
      req_ready  = 2'b00;
      rsp_valid  = 2'b00;
      case (state_q)
         IDLE: begin
            if (grant_any) begin
               req_ready = grant_idx ? 2'b10 : 2'b01;
               alu_a_d   = slice_a[grant_idx];
               alu_b_d   = slice_b[grant_idx];
               alu_sel_d = slice_sel[grant_idx];
               owner_d   = grant_idx;
               rr_ptr_d  = ~grant_idx;
               lat_cnt_d = '0;
               state_d   = EXEC;
            end
         end
         EXEC: begin
            // Final EXEC cycle: the ALU's registered output now reflects our operands.
            if (lat_cnt_q == LAT_LAST) begin
               rsp_out_d  = alu_out;
               rsp_flag_d = alu_flag;
               state_d    = RESP;
            end else begin
               lat_cnt_d = lat_cnt_q + CW'(1);
            end
         end
         RESP: begin
            rsp_valid = owner_q ? 2'b10 : 2'b01;
            if (rsp_ready[owner_q]) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rr_ptr_q   <= 1'b0;
         owner_q    <= 1'b0;
         lat_cnt_q  <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_sel_q  <= '0;
         rsp_out_q  <= '0;
         rsp_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         lat_cnt_q  <= lat_cnt_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_sel_q  <= alu_sel_d;
         rsp_out_q  <= rsp_out_d;
         rsp_flag_q <= rsp_flag_d;
      end
   end

   assign alu_a    = alu_a_q;
   assign alu_b    = alu_b_q;
   assign alu_sel  = alu_sel_q;
   assign rsp_out  = rsp_out_q;
   assign rsp_flag = rsp_flag_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Bench for alu_rr_sequencer: directed scenarios plus random traffic, checked
// against a transaction-level model of grant order, latency and results.
module tb_alu_rr_sequencer;
   localparam int W   = 32;
   localparam int LAT = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // main instance (ALU_LAT=1)
   logic [1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
   logic [2*W-1:0] req_a, req_b;
   logic [7:0]     req_sel;
   logic [W-1:0]   alu_a, alu_b, alu_out, rsp_out;
   logic [3:0]     alu_sel;
   logic           alu_flag, rsp_flag, busy;

   // second instance (ALU_LAT=3)
   logic [1:0]     req_valid3, req_ready3, rsp_valid3, rsp_ready3;
   logic [2*W-1:0] req_a3, req_b3;
   logic [7:0]     req_sel3;
   logic [W-1:0]   alu_a3, alu_b3, alu_out3, rsp_out3;
   logic [3:0]     alu_sel3;
   logic           alu_flag3, rsp_flag3, busy3;

   alu_rr_sequencer #(.WIDTH(W), .ALU_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .alu_a(alu_a), .alu_b(alu_b),
      .alu_sel(alu_sel), .alu_out(alu_out), .alu_flag(alu_flag), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_out(rsp_out), .rsp_flag(rsp_flag), .busy(busy));

   alu_rr_sequencer #(.WIDTH(W), .ALU_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
      .req_a(req_a3), .req_b(req_b3), .req_sel(req_sel3), .alu_a(alu_a3), .alu_b(alu_b3),
      .alu_sel(alu_sel3), .alu_out(alu_out3), .alu_flag(alu_flag3), .rsp_valid(rsp_valid3),
      .rsp_ready(rsp_ready3), .rsp_out(rsp_out3), .rsp_flag(rsp_flag3), .busy(busy3));

   function automatic logic [W:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [3:0] s);
      logic [W-1:0] r;
      case (s)
         4'd0:    r = a + b;
         4'd1:    r = a - b;
         4'd2:    r = a & b;
         4'd3:    r = a | b;
         4'd4:    r = a ^ b;
         default: r = a;
      endcase
      return {(r == '0), r};
   endfunction

   // shared ALUs: one register stage, and a three-stage pipe
   always @(posedge clk) {alu_flag, alu_out} <= alu_f(alu_a, alu_b, alu_sel);
   logic [W:0] pipe3 [3];
   always @(posedge clk) begin
      pipe3[0] <= alu_f(alu_a3, alu_b3, alu_sel3);
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign {alu_flag3, alu_out3} = pipe3[2];

   int n_chk = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // transaction-level model of the main instance
   bit           m_idle = 1'b1;
   bit           m_last = 1'b1;
   bit           m_owner = 1'b0;
   int           m_cnt = 0;
   logic [W-1:0] m_a = '0, m_b = '0, m_out = '0, m_eout = '0;
   logic [3:0]   m_sel = '0;
   logic         m_flag = 1'b0, m_eflag = 1'b0;
   int           cyc = 0;
   int           g_last = -1;
   logic [1:0]   last_rv, last_rdy;
   logic         last_busy;
   logic [W:0]   last_rsp;
   int           acc_q[$];
   int           acc_cyc[$];

   task automatic model_reset();
      m_idle = 1'b1; m_last = 1'b1; m_cnt = 0;
      m_a = '0; m_b = '0; m_sel = '0; m_out = '0; m_flag = 1'b0;
   endtask

   // Entered just after a rising edge with this cycle's inputs applied; returns one cycle later.
   task automatic cycle_check();
      int g;
      logic [1:0] exp_rdy;
      g = -1;
      #1;
      last_rv = rsp_valid; last_rdy = req_ready; last_busy = busy; last_rsp = {rsp_flag, rsp_out};
      check_eq("alu_ops_hold", {alu_sel, alu_a, alu_b}, {m_sel, m_a, m_b});
      if (m_idle) begin
         if (req_valid == 2'b01)      g = 0;
         else if (req_valid == 2'b10) g = 1;
         else if (req_valid == 2'b11) g = m_last ? 0 : 1;
         exp_rdy = (g < 0) ? 2'b00 : ((g == 1) ? 2'b10 : 2'b01);
         check_eq("req_ready_idle", req_ready, exp_rdy);
         check_eq("busy_idle", busy, 0);
         check_eq("rsp_valid_idle", rsp_valid, 0);
         check_eq("rsp_hold_idle", {rsp_flag, rsp_out}, {m_flag, m_out});
         if (g >= 0) begin
            m_a = req_a[g*W +: W]; m_b = req_b[g*W +: W]; m_sel = req_sel[g*4 +: 4];
            {m_eflag, m_eout} = alu_f(m_a, m_b, m_sel);
            m_owner = g[0]; m_last = g[0]; m_idle = 1'b0; m_cnt = 0;
            acc_q.push_back(g); acc_cyc.push_back(cyc);
            $display("[%0t] accept req%0d a=%h b=%h sel=%0d -> out=%h flag=%0b",
                     $time, g, m_a, m_b, m_sel, m_eout, m_eflag);
         end
      end else begin
         m_cnt++;
         check_eq("req_ready_busy", req_ready, 0);
         check_eq("busy_active", busy, 1);
         if (m_cnt <= LAT + 1) begin
            check_eq("rsp_valid_exec", rsp_valid, 0);
            check_eq("rsp_hold_exec", {rsp_flag, rsp_out}, {m_flag, m_out});
         end else begin
            check_eq("rsp_valid_owner", rsp_valid, m_owner ? 2'b10 : 2'b01);
            check_eq("rsp_data", {rsp_flag, rsp_out}, {m_eflag, m_eout});
            if (rsp_ready[m_owner]) begin
               m_idle = 1'b1; m_out = m_eout; m_flag = m_eflag;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      g_last = g;
   endtask

   task automatic set_req(input int i, input bit v, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [3:0] s);
      req_valid[i] = v; req_a[i*W +: W] = a; req_b[i*W +: W] = b; req_sel[i*4 +: 4] = s;
   endtask

   task automatic new_req(input int i);
      logic [W-1:0] a, b;
      logic [3:0] s;
      a = $urandom; b = $urandom; s = 4'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) begin b = a; s = 4'd1; end
      set_req(i, 1'b1, a, b, s);
   endtask

   task automatic drain();
      int n;
      n = 0;
      req_valid = 2'b00; rsp_ready = 2'b11;
      while (!m_idle && n < 20) begin cycle_check(); n++; end
      check_eq("drain_timeout", (n < 20), 1);
      cycle_check();
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq(tag, {req_ready, rsp_valid, rsp_flag, busy}, 0);
      check_eq({tag, "_data"}, {rsp_out, alu_a, alu_b, alu_sel}, 0);
   endtask

   initial begin
      int base, n, op0, op1;
      rst_n = 1'b0;
      req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = '0;
      req_valid3 = '0; req_a3 = '0; req_b3 = '0; req_sel3 = '0; rsp_ready3 = 2'b11;
      #1;
      check_outputs_zero("reset_out");
      check_eq("reset_out3", {req_ready3, rsp_valid3, busy3, rsp_out3, alu_a3}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // ALU_LAT=3: req1 accepted at cycle 0, response at cycle 5
      req_valid3 = 2'b10; req_a3 = {32'd7, 32'd0}; req_b3 = {32'd9, 32'd0}; req_sel3 = 8'h00;
      #1 check_eq("t5_ready", req_ready3, 2'b10);
      @(posedge clk); #1;
      req_valid3 = 2'b00; req_a3 = '1; req_b3 = '1; req_sel3 = 8'hFF;
      $display("[%0t] accept lat3 req1 a=7 b=9 sel=0 -> out=16", $time);
      for (int k = 1; k <= 6; k++) begin
         #1;
         check_eq("t5_busy", busy3, (k <= 5));
         check_eq("t5_rsp_valid", rsp_valid3, (k == 5) ? 2'b10 : 2'b00);
         check_eq("t5_alu_ops", {alu_sel3, alu_a3, alu_b3}, {4'd0, 32'd7, 32'd9});
         if (k == 5) check_eq("t5_rsp", {rsp_flag3, rsp_out3}, {1'b0, 32'd16});
         @(posedge clk); #1;
      end

      // only req0: 5+3
      rsp_ready = 2'b11;
      set_req(0, 1'b1, 32'd5, 32'd3, 4'd0);
      cycle_check();
      check_eq("t1_ready", last_rdy, 2'b01);
      req_valid[0] = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         cycle_check();
         check_eq("t1_busy", last_busy, (k <= 3));
         check_eq("t1_rsp_valid", last_rv, (k == 3) ? 2'b01 : 2'b00);
         if (k == 3) check_eq("t1_rsp", last_rsp, {1'b0, 32'd8});
      end

      // reset back to a fresh pointer, then both valid: alternating grants
      @(negedge clk) rst_n = 1'b0;
      #1 check_outputs_zero("reset_idle");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      model_reset();
      set_req(0, 1'b1, 32'd1, 32'hFFFF_FFFF, 4'd0);
      new_req(1);
      base = acc_q.size(); n = 0; op0 = 1; op1 = 1;
      while (acc_q.size() < base + 8 && n < 100) begin
         cycle_check(); n++;
         if (g_last == 0) begin
            if (op0 < 4) begin new_req(0); op0++; end else req_valid[0] = 1'b0;
         end else if (g_last == 1) begin
            if (op1 < 4) begin new_req(1); op1++; end else req_valid[1] = 1'b0;
         end
      end
      check_eq("t2_timeout", (n < 100), 1);
      for (int k = 0; k < 8; k++)
         if (base + k < acc_q.size()) check_eq("t2_order", acc_q[base + k], k % 2);
      drain();

      // backpressure on req0 while req1 waits
      new_req(0); new_req(1); rsp_ready = 2'b10;
      cycle_check();
      check_eq("t3_first_grant", g_last, 0);
      req_valid[0] = 1'b0;
      n = 0;
      while (last_rv != 2'b01 && n < 10) begin cycle_check(); n++; end
      check_eq("t3_timeout", (n < 10), 1);
      for (int k = 0; k < 5; k++) begin
         cycle_check();
         check_eq("t3_rsp_held", last_rv, 2'b01);
         check_eq("t3_no_grant", g_last, -1);
      end
      rsp_ready = 2'b11;
      cycle_check();
      check_eq("t3_no_grant_hs", g_last, -1);
      cycle_check();
      check_eq("t3_req1_grant", g_last, 1);
      drain();

      // only req1, back-to-back
      base = acc_q.size(); n = 0; op1 = 1;
      new_req(1);
      while (acc_q.size() < base + 3 && n < 40) begin
         cycle_check(); n++;
         if (g_last == 1) begin
            if (op1 < 3) begin new_req(1); op1++; end else req_valid[1] = 1'b0;
         end
      end
      check_eq("t6_timeout", (n < 40), 1);
      for (int k = 0; k < 3; k++)
         if (base + k < acc_q.size()) check_eq("t6_owner", acc_q[base + k], 1);
      for (int k = 1; k < 3; k++)
         if (base + k < acc_q.size())
            check_eq("t6_spacing", acc_cyc[base + k] - acc_cyc[base + k - 1], LAT + 3);
      drain();

      // random traffic
      for (int c = 0; c < 400; c++) begin
         rsp_ready = 2'($urandom);
         for (int i = 0; i < 2; i++) begin
            if (!req_valid[i]) begin
               if ($urandom_range(0, 2) == 0) new_req(i);
            end else if ($urandom_range(0, 15) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         cycle_check();
         if (g_last >= 0) req_valid[g_last] = 1'b0;
      end
      drain();

      // reset during EXEC drops the op and restores the pointer
      new_req(0);
      cycle_check();
      check_eq("t4_grant_before", g_last, 0);
      req_valid = 2'b00;
      #2 rst_n = 1'b0;
      #1 check_outputs_zero("t4_async");
      repeat (2) @(posedge clk);
      #1 check_outputs_zero("t4_held");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      model_reset();
      repeat (4) cycle_check();
      new_req(0); new_req(1);
      cycle_check();
      check_eq("t4_grant_after", g_last, 0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
